// File: rtl/wb_master_arbiter_pkg.sv
// Shared types and defaults for the two-master Wishbone arbiter.
// State encodings, master identifiers and the default watchdog timeout.
package wb_master_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } mst_id_e;

    localparam int REG_BUS            = 32;
    localparam int WB_TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/wb_master_arbiter_watchdog.sv
// Bus watchdog: counts waiting cycles of the granted access and terminates it.
// The termination pulse is combinational; the sticky flag also reflects the pulse cycle.
module wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CW             = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic ack_i,
    output logic term_o,
    output logic timeout_o
);

    localparam logic [CW-1:0] TERM_AT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] wdog_q, wdog_d;
    logic          flag_q, flag_d;

    assign term_o    = (TIMEOUT_CYCLES > 0) && active_i && !ack_i && (wdog_q == TERM_AT);
    assign timeout_o = flag_q | term_o;

    always_comb begin
        wdog_d = wdog_q;
        flag_d = flag_q | term_o;
        if (!active_i || ack_i || term_o) begin
            wdog_d = '0;
        end else if (wdog_q != {CW{1'b1}}) begin
            wdog_d = wdog_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
            flag_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            flag_q <= flag_d;
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master to one-slave Wishbone classic arbiter with alternating tie-break and watchdog.
// Grant is registered (one cycle after cyc at earliest); datapath is combinational from the grant.
module wb_master_arbiter
    import wb_master_arbiter_pkg::*;
#(
    parameter int DW             = REG_BUS,
    parameter int AW             = 32,
    parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT,
    parameter int CW             = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   m0_addr_i,
    input  logic [DW-1:0]   m0_data_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_stb_i,
    input  logic            m0_cyc_i,
    output logic [DW-1:0]   m0_data_o,
    output logic            m0_ack_o,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic [DW-1:0]   m1_data_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_stb_i,
    input  logic            m1_cyc_i,
    output logic [DW-1:0]   m1_data_o,
    output logic            m1_ack_o,
    output logic [AW-1:0]   s_addr_o,
    output logic [DW-1:0]   s_data_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_stb_o,
    output logic            s_cyc_o,
    input  logic [DW-1:0]   s_data_i,
    input  logic            s_ack_i,
    output logic            timeout_o
);

    arb_state_e state_q;
    mst_id_e    last_q;
    logic       gnt0, gnt1, term;

    assign gnt0 = (state_q == ST_GNT0);
    assign gnt1 = (state_q == ST_GNT1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            last_q  <= MST_M1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (m0_cyc_i && m1_cyc_i) begin
                        state_q <= (last_q == MST_M1) ? ST_GNT0 : ST_GNT1;
                    end else if (m0_cyc_i) begin
                        state_q <= ST_GNT0;
                    end else if (m1_cyc_i) begin
                        state_q <= ST_GNT1;
                    end
                end
                ST_GNT0: begin
                    if (!m0_cyc_i) begin
                        state_q <= ST_IDLE;
                        last_q  <= MST_M0;
                    end
                end
                ST_GNT1: begin
                    if (!m1_cyc_i) begin
                        state_q <= ST_IDLE;
                        last_q  <= MST_M1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CW             (CW)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .active_i  ((gnt0 && m0_stb_i) || (gnt1 && m1_stb_i)),
        .ack_i     (s_ack_i),
        .term_o    (term),
        .timeout_o (timeout_o)
    );

    // A watchdog termination hides the access from the slave and fakes an ack with zero data.
    always_comb begin
        s_addr_o  = '0;
        s_data_o  = '0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_stb_o   = 1'b0;
        s_cyc_o   = 1'b0;
        m0_ack_o  = 1'b0;
        m0_data_o = '0;
        m1_ack_o  = 1'b0;
        m1_data_o = '0;
        if (gnt0) begin
            s_addr_o  = m0_addr_i;
            s_data_o  = m0_data_i;
            s_we_o    = m0_we_i;
            s_sel_o   = m0_sel_i;
            s_stb_o   = m0_stb_i && !term;
            s_cyc_o   = m0_cyc_i && !term;
            m0_ack_o  = s_ack_i || term;
            m0_data_o = term ? '0 : s_data_i;
        end else if (gnt1) begin
            s_addr_o  = m1_addr_i;
            s_data_o  = m1_data_i;
            s_we_o    = m1_we_i;
            s_sel_o   = m1_sel_i;
            s_stb_o   = m1_stb_i && !term;
            s_cyc_o   = m1_cyc_i && !term;
            m1_ack_o  = s_ack_i || term;
            m1_data_o = term ? '0 : s_data_i;
        end
    end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_wb_master_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int T  = 16;
    localparam int CW = 9;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [AW-1:0]   m0_addr_i = '0, m1_addr_i = '0;
    logic [DW-1:0]   m0_data_i = '0, m1_data_i = '0;
    logic            m0_we_i = 1'b0, m1_we_i = 1'b0;
    logic [DW/8-1:0] m0_sel_i = '0, m1_sel_i = '0;
    logic            m0_stb_i = 1'b0, m1_stb_i = 1'b0;
    logic            m0_cyc_i = 1'b0, m1_cyc_i = 1'b0;
    logic [DW-1:0]   m0_data_o, m1_data_o;
    logic            m0_ack_o, m1_ack_o;
    logic [AW-1:0]   s_addr_o;
    logic [DW-1:0]   s_data_o;
    logic            s_we_o;
    logic [DW/8-1:0] s_sel_o;
    logic            s_stb_o, s_cyc_o;
    logic [DW-1:0]   s_data_i = '0;
    logic            s_ack_i = 1'b0;
    logic            timeout_o;

    always #5 clk = ~clk;

    wb_master_arbiter #(.DW(DW), .AW(AW), .TIMEOUT_CYCLES(T), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
        .timeout_o(timeout_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the bus, who was served last,
    // how many consecutive unanswered strobe cycles, and whether a timeout ever fired.
    int owner   = -1;
    int last    = 1;
    int waiting = 0;
    bit sticky  = 1'b0;

    function automatic bit owner_stb();
        return (owner == 0) ? m0_stb_i : (owner == 1) ? m1_stb_i : 1'b0;
    endfunction

    function automatic bit owner_cyc();
        return (owner == 0) ? m0_cyc_i : (owner == 1) ? m1_cyc_i : 1'b0;
    endfunction

    function automatic bit mdl_term();
        return (owner >= 0) && owner_stb() && !s_ack_i && (waiting == T - 1);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner = -1; last = 1; waiting = 0; sticky = 1'b0;
        end else if (owner < 0) begin
            if (m0_cyc_i && m1_cyc_i) owner = 1 - last;
            else if (m0_cyc_i)        owner = 0;
            else if (m1_cyc_i)        owner = 1;
            waiting = 0;
        end else begin
            if (mdl_term()) begin
                sticky  = 1'b1;
                waiting = 0;
            end else if (owner_stb() && !s_ack_i) begin
                waiting = waiting + 1;
            end else begin
                waiting = 0;
            end
            if (!owner_cyc()) begin
                last    = owner;
                owner   = -1;
                waiting = 0;
            end
        end
    end

    task automatic compare();
        logic [AW-1:0]   ea = '0;
        logic [DW-1:0]   ed = '0, ed0 = '0, ed1 = '0;
        logic [DW/8-1:0] es = '0;
        logic            ewe = 1'b0, estb = 1'b0, ecyc = 1'b0, ea0 = 1'b0, ea1 = 1'b0;
        bit term;
        term = mdl_term();
        if (owner == 0) begin
            ea = m0_addr_i; ed = m0_data_i; ewe = m0_we_i; es = m0_sel_i;
            estb = m0_stb_i && !term; ecyc = m0_cyc_i && !term;
            ea0 = s_ack_i || term; ed0 = term ? '0 : s_data_i;
        end else if (owner == 1) begin
            ea = m1_addr_i; ed = m1_data_i; ewe = m1_we_i; es = m1_sel_i;
            estb = m1_stb_i && !term; ecyc = m1_cyc_i && !term;
            ea1 = s_ack_i || term; ed1 = term ? '0 : s_data_i;
        end
        chk("mdl s_addr", 64'(s_addr_o), 64'(ea));
        chk("mdl s_data", 64'(s_data_o), 64'(ed));
        chk("mdl s_we", 64'(s_we_o), 64'(ewe));
        chk("mdl s_sel", 64'(s_sel_o), 64'(es));
        chk("mdl s_stb", 64'(s_stb_o), 64'(estb));
        chk("mdl s_cyc", 64'(s_cyc_o), 64'(ecyc));
        chk("mdl m0_ack", 64'(m0_ack_o), 64'(ea0));
        chk("mdl m0_data", 64'(m0_data_o), 64'(ed0));
        chk("mdl m1_ack", 64'(m1_ack_o), 64'(ea1));
        chk("mdl m1_data", 64'(m1_data_o), 64'(ed1));
        chk("mdl timeout", 64'(timeout_o), 64'(sticky || term));
    endtask

    always @(negedge clk) if (rst) compare();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        s_ack_i  = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, " s_cyc"}, 64'(s_cyc_o), 64'd0);
        chk({tag, " s_stb"}, 64'(s_stb_o), 64'd0);
        chk({tag, " s_addr"}, 64'(s_addr_o), 64'd0);
        chk({tag, " s_data"}, 64'(s_data_o), 64'd0);
        chk({tag, " m0_ack"}, 64'(m0_ack_o), 64'd0);
        chk({tag, " m0_data"}, 64'(m0_data_o), 64'd0);
        chk({tag, " timeout"}, 64'(timeout_o), 64'd0);
    endtask

    int seq[$];
    bit a0, a1;

    initial begin
        // Reset with busy inputs: outputs must stay zero.
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 32'h0000_0900; m0_data_i = 32'h1;
        s_ack_i = 1'b1; s_data_i = 32'hFFFF_FFFF;
        repeat (2) tick();
        all_zero("reset");
        idle_all();
        @(negedge clk) rst = 1'b1;

        // Simultaneous requests after reset: m0 first, one dead cycle, then m1.
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h200;
        m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h300;
        @(negedge clk) chk("tie idle s_cyc", 64'(s_cyc_o), 0);
        tick(); s_ack_i = 1; s_data_i = 32'h11;
        @(negedge clk);
        chk("tie first addr", 64'(s_addr_o), 64'h200);
        chk("tie m0_ack", 64'(m0_ack_o), 1);
        chk("tie m1_ack", 64'(m1_ack_o), 0);
        tick(); m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        @(negedge clk) chk("tie drop s_cyc", 64'(s_cyc_o), 0);
        tick();
        @(negedge clk) chk("tie dead s_cyc", 64'(s_cyc_o), 0);
        tick();
        @(negedge clk);
        chk("tie second s_cyc", 64'(s_cyc_o), 1);
        chk("tie second addr", 64'(s_addr_o), 64'h300);
        tick(); idle_all();
        repeat (2) tick();

        // Continuous single-beat requests from both: grants alternate 0,1,0,1.
        s_ack_i = 1; s_data_i = 32'h22;
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        for (int c = 0; c < 40 && seq.size() < 4; c++) begin
            @(negedge clk);
            a0 = m0_ack_o && m0_stb_i;
            a1 = m1_ack_o && m1_stb_i;
            if (a0) seq.push_back(0);
            if (a1) seq.push_back(1);
            tick();
            m0_cyc_i = !a0; m0_stb_i = !a0;
            m1_cyc_i = !a1; m1_stb_i = !a1;
        end
        chk("alt count", 64'(seq.size()), 64'd4);
        for (int i = 0; i < seq.size(); i++) chk("alt order", 64'(seq[i]), 64'(i % 2));
        idle_all();
        repeat (3) tick();

        // Lone m0 read.
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_addr_i = 32'h100; m0_sel_i = 4'hF;
        @(negedge clk) chk("lone idle s_cyc", 64'(s_cyc_o), 0);
        tick();
        @(negedge clk);
        chk("lone s_cyc", 64'(s_cyc_o), 1);
        chk("lone s_addr", 64'(s_addr_o), 64'h100);
        chk("lone early ack", 64'(m0_ack_o), 0);
        tick(); s_ack_i = 1; s_data_i = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("lone m0_ack", 64'(m0_ack_o), 1);
        chk("lone m0_data", 64'(m0_data_o), 64'hDEAD_BEEF);
        chk("lone m1_ack", 64'(m1_ack_o), 0);
        tick(); idle_all();
        repeat (2) tick();

        // m1 holds a 3-beat burst while m0 waits: no preemption.
        m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h500; s_ack_i = 1; s_data_i = 32'h33;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h400;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            chk("burst addr", 64'(s_addr_o), 64'h500);
            chk("burst m1_ack", 64'(m1_ack_o), 1);
            chk("burst m0_ack", 64'(m0_ack_o), 0);
            tick();
        end
        m1_cyc_i = 0; m1_stb_i = 0;
        @(negedge clk) chk("burst drop s_cyc", 64'(s_cyc_o), 0);
        tick();
        @(negedge clk) chk("burst dead s_cyc", 64'(s_cyc_o), 0);
        tick();
        @(negedge clk);
        chk("burst m0 s_cyc", 64'(s_cyc_o), 1);
        chk("burst m0 addr", 64'(s_addr_o), 64'h400);
        tick(); idle_all();
        repeat (2) tick();

        // Watchdog: m1 write never acked.
        chk("pre timeout", 64'(timeout_o), 0);
        s_data_i = 32'hAAAA_5555;
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_addr_i = 32'h600; m1_data_i = 32'h1234;
        for (int k = 1; k <= T; k++) begin
            tick();
            @(negedge clk);
            if (k == T - 1) begin
                chk("wd pre ack", 64'(m1_ack_o), 0);
                chk("wd pre s_cyc", 64'(s_cyc_o), 1);
            end
            if (k == T) begin
                chk("wd m1_ack", 64'(m1_ack_o), 1);
                chk("wd m1_data", 64'(m1_data_o), 0);
                chk("wd s_cyc", 64'(s_cyc_o), 0);
                chk("wd s_stb", 64'(s_stb_o), 0);
                chk("wd timeout", 64'(timeout_o), 1);
            end
        end
        tick(); idle_all();
        @(negedge clk) chk("wd sticky 1", 64'(timeout_o), 1);
        tick();
        @(negedge clk) chk("wd sticky 2", 64'(timeout_o), 1);

        // Asynchronous reset in the middle of an m0 access.
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h700; m0_data_i = 32'h77; s_ack_i = 1; s_data_i = 32'h55;
        tick();
        @(negedge clk) chk("ar pre s_cyc", 64'(s_cyc_o), 1);
        #2 rst = 1'b0;
        #1 all_zero("ar async");
        tick();
        m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h800;
        all_zero("ar held");
        @(negedge clk) rst = 1'b1;
        tick();
        @(negedge clk);
        chk("ar tie addr", 64'(s_addr_o), 64'h700);
        chk("ar tie m1_ack", 64'(m1_ack_o), 0);
        tick(); idle_all();
        repeat (2) tick();

        // Random traffic with varying slave responsiveness.
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 300; c++) begin
                tick();
                m0_cyc_i = m0_cyc_i ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 2) == 0);
                m1_cyc_i = m1_cyc_i ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 2) == 0);
                m0_stb_i = m0_cyc_i && ($urandom_range(0, 9) != 0);
                m1_stb_i = m1_cyc_i && ($urandom_range(0, 9) != 0);
                m0_we_i = 1'($urandom); m1_we_i = 1'($urandom);
                m0_addr_i = $urandom; m1_addr_i = $urandom;
                m0_data_i = $urandom; m1_data_i = $urandom;
                m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
                s_data_i = $urandom;
                s_ack_i = ($urandom_range(0, 3) < ph);
            end
        end
        tick(); idle_all();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
